// File: rtl/line_buf_wr_ctrl.sv
// Line-buffer write controller: pixel stream -> rotating 6-bank row writes, optional zero border (LBW_PAD_EN).
// Latency: one cycle from consume/pad decision to wr_en_o; ctrl_reset_o one cycle after the last ctrl_update_o.
// Backpressure: pix_ready_o high only on interior ROW columns; pix_valid_i low simply stalls the column counter.
module line_buf_wr_ctrl #(
    parameter int DW = 8
) (
    input  logic          SYS_CLK,
    input  logic          SYS_NRST,
    input  logic          start_i,
    input  logic [7:0]    pic_size_i,
    input  logic          padding_i,
    input  logic          pix_valid_i,
    input  logic [DW-1:0] pix_data_i,
    output logic          pix_ready_o,
    output logic          wr_en_o,
    output logic [2:0]    wr_bank_o,
    output logic [7:0]    wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    output logic          ctrl_update_o,
    output logic          ctrl_reset_o,
    output logic          busy_o
);

    typedef enum logic [2:0] {IDLE, PAD_TOP, ROW, PAD_BOT, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    size_q, size_d;
    logic          pad_q, pad_d;
    logic [8:0]    col_q, col_d;
    logic [7:0]    row_q, row_d;
    logic [2:0]    bank_q, bank_d;
    logic          wr_en_q, wr_en_d;
    logic [2:0]    wr_bank_q, wr_bank_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          upd_q, upd_d;
    logic          rst_q, rst_d;

    logic          pad_in;
    logic [8:0]    width_w;
    logic [8:0]    last_col;
    logic          border;
    logic          do_wr;
    logic [DW-1:0] wdat;
    logic          row_end;

`ifdef LBW_PAD_EN
    assign pad_in = padding_i;
`else
    logic unused_padding;
    assign unused_padding = padding_i;
    assign pad_in         = 1'b0;
`endif

    assign width_w  = {1'b0, size_q} + {7'b0, pad_q, 1'b0};
    assign last_col = width_w - 9'd1;
    assign border   = pad_q && ((col_q == 9'd0) || (col_q == last_col));

    assign pix_ready_o   = (state_q == ROW) && !border;
    assign busy_o        = (state_q != IDLE);
    assign wr_en_o       = wr_en_q;
    assign wr_bank_o     = wr_bank_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign ctrl_update_o = upd_q;
    assign ctrl_reset_o  = rst_q;

    // Write decision for this cycle: pad rows always write, ROW writes on border or accepted pixel.
    always_comb begin
        do_wr = 1'b0;
        wdat  = '0;
        case (state_q)
`ifdef LBW_PAD_EN
            PAD_TOP, PAD_BOT: do_wr = 1'b1;
`endif
            ROW: begin
                if (border) begin
                    do_wr = 1'b1;
                end else if (pix_valid_i) begin
                    do_wr = 1'b1;
                    wdat  = pix_data_i;
                end
            end
            default: do_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        pad_d     = pad_q;
        col_d     = col_q;
        row_d     = row_q;
        bank_d    = bank_q;
        wr_en_d   = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        upd_d     = 1'b0;
        rst_d     = 1'b0;
        row_end   = 1'b0;

        if (do_wr) begin
            wr_en_d   = 1'b1;
            wr_bank_d = bank_q;
            wr_addr_d = col_q[7:0];
            wr_data_d = wdat;
            if (col_q == last_col) begin
                upd_d   = 1'b1;
                row_end = 1'b1;
                col_d   = 9'd0;
                bank_d  = (bank_q == 3'd5) ? 3'd0 : bank_q + 3'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    size_d = pic_size_i;
                    pad_d  = pad_in;
                    col_d  = 9'd0;
                    row_d  = 8'd0;
                    bank_d = 3'd0;
`ifdef LBW_PAD_EN
                    state_d = pad_in ? PAD_TOP : ROW;
`else
                    state_d = ROW;
`endif
                end
            end
`ifdef LBW_PAD_EN
            PAD_TOP: if (row_end) state_d = ROW;
            PAD_BOT: if (row_end) state_d = DONE;
`endif
            ROW: begin
                if (row_end) begin
                    row_d = row_q + 8'd1;
                    if (row_q == size_q - 8'd1) begin
`ifdef LBW_PAD_EN
                        state_d = pad_q ? PAD_BOT : DONE;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE: begin
                rst_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state_q   <= IDLE;
            size_q    <= '0;
            pad_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            bank_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            upd_q     <= 1'b0;
            rst_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            pad_q     <= pad_d;
            col_q     <= col_d;
            row_q     <= row_d;
            bank_q    <= bank_d;
            wr_en_q   <= wr_en_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            upd_q     <= upd_d;
            rst_q     <= rst_d;
        end
    end

endmodule

// File: doc/line_buf_wr_ctrl.md
LINE_BUF_WR_CTRL -- requirements
Module: line_buf_wr_ctrl

Interface
REQ-001 Parameter: DW, 8, pixel data width in bits.
REQ-002 SYS_CLK  input  1  clock, all state on rising edge.
REQ-003 SYS_NRST  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  single-cycle frame start request.
REQ-005 pic_size_i  input  8  input frame width/height in pixels, legal range 3..254.
REQ-006 padding_i  input  1  1 = add one-pixel zero border on all sides.
REQ-007 pix_valid_i  input  1  input pixel valid.
REQ-008 pix_data_i  input  DW  input pixel, raster order.
REQ-009 pix_ready_o  output  1  block accepts pixel this cycle.
REQ-010 wr_en_o  output  1  row-bank write strobe.
REQ-011 wr_bank_o  output  3  target row bank, 0..5.
REQ-012 wr_addr_o  output  8  column address within bank.
REQ-013 wr_data_o  output  DW  write data.
REQ-014 ctrl_update_o  output  1  one-cycle pulse per completed row, drives mux controller update.
REQ-015 ctrl_reset_o  output  1  one-cycle pulse at frame end, drives mux controller reset.
REQ-016 busy_o  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL latch pic_size_i and padding_i on an accepted start_i; row width W = pic_size + 2*padding, computed at 9 bits.
REQ-018 FSM states SHALL be IDLE, PAD_TOP, ROW, PAD_BOT, DONE.
REQ-019 IDLE->PAD_TOP on start_i if padding, else IDLE->ROW; start_i outside IDLE SHALL be ignored.
REQ-020 PAD_TOP/PAD_BOT SHALL write W zeros, one per cycle, addr 0..W-1, pix_ready_o low throughout.
REQ-021 In ROW, columns 0 and W-1 SHALL be written as zero without consuming input when padding=1; pix_ready_o SHALL be high only on interior columns.
REQ-022 A pixel SHALL be consumed when pix_valid_i & pix_ready_o; wr_en_o/wr_addr_o/wr_data_o/wr_bank_o SHALL be registered, asserted exactly one cycle after the consume or pad-write decision.
REQ-023 ctrl_update_o SHALL pulse in the same cycle as wr_en_o for column W-1 of every row, including pad rows.
REQ-024 After column W-1 the column counter SHALL return to 0 and bank SHALL advance 0->1->...->5->0.
REQ-025 Bank SHALL be 0 for the first row of every frame.
REQ-026 After pic_size input rows ROW SHALL go to PAD_BOT if padding, else DONE; PAD_BOT ends in DONE.
REQ-027 DONE SHALL last one cycle; ctrl_reset_o SHALL pulse one cycle after the last ctrl_update_o, then IDLE.
REQ-028 pix_valid_i low in ROW SHALL stall the column counter with no write and no timeout.
REQ-029 Total ctrl_update_o pulses per frame SHALL equal pic_size + 2*padding.

Reset
REQ-030 On SYS_NRST low all outputs SHALL be 0, FSM SHALL be IDLE, counters and bank SHALL be 0, asynchronously.
REQ-031 Reset mid-frame SHALL abandon the frame with no ctrl_update_o or ctrl_reset_o pulse after release.

Configuration
REQ-032 Macro LBW_PAD_EN: defined -> padding support per REQ-017..REQ-026; undefined -> padding_i ignored, treated as 0, PAD_TOP/PAD_BOT logic SHALL not be compiled.

Verification
REQ-033 pic_size=4, padding=0, 16 back-to-back pixels 1..16 -> 16 writes, 4 ctrl_update_o pulses, banks 0..3, then one ctrl_reset_o.
REQ-034 pic_size=4, padding=1 -> 6 rows of W=6: row 0 and row 5 all zero; interior rows zero at addr 0 and 5; 6 ctrl_update_o pulses.
REQ-035 pic_size=8, padding=0 -> banks sequence 0,1,2,3,4,5,0,1; second frame starts at bank 0.
REQ-036 pix_valid_i toggling 1/0 each cycle, pic_size=3 -> 9 writes, addresses contiguous, no write on idle cycles.
REQ-037 SYS_NRST pulsed low during row 2 -> all outputs 0, busy_o 0, no ctrl_reset_o; next start_i frame is correct.
REQ-038 start_i asserted while busy_o=1 -> ignored, current frame completes unchanged.
